// File: rtl/student_or_reduce_pipe.sv
// Pipelined OR-reduction tree with valid/ready handshake and a sticky any-one flag.
// One tree level is registered per cycle; the whole pipeline stalls together.

module student_or (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i | b_i;
endmodule

module student_or_reduce_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             out_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             sticky_o,
    input  logic             sticky_clear_i
);
    localparam int LEVELS = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam int PAD    = 1 << LEVELS;

    logic [PAD-1:0]     in_pad;
    logic [2*PAD-1:1]   node;
    logic [PAD-1:1]     node_q;
    logic [PAD-1:1]     node_d;
    logic [LEVELS:1]    v_q;
    logic [LEVELS:1]    v_d;
    logic               sticky_q;
    logic               sticky_d;
    logic               advance;
    logic               out_xfer;

    always_comb begin
        in_pad              = '0;
        in_pad[WIDTH-1:0]   = in_i;
    end

    // Heap-indexed tree: node i is the OR of nodes 2i and 2i+1; leaves are the padded input.
    assign node = {in_pad, node_q};

    genvar gi;
    for (gi = 1; gi < PAD; gi++) begin : g_or
        student_or u_or (
            .a_i (node[2*gi]),
            .b_i (node[2*gi+1]),
            .y_o (node_d[gi])
        );
    end

    assign advance  = v_q[LEVELS] ? out_ready_i : 1'b1;
    assign out_xfer = v_q[LEVELS] & out_ready_i;

    always_comb begin
        v_d    = '0;
        v_d[1] = in_valid_i;
        for (int k = 2; k <= LEVELS; k++) begin
            v_d[k] = v_q[k-1];
        end
    end

    // A set on a 1-transfer takes priority over a coincident clear.
    always_comb begin
        sticky_d = sticky_q;
        if (out_xfer & node_q[1]) begin
            sticky_d = 1'b1;
        end else if (sticky_clear_i) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            node_q   <= '0;
            v_q      <= '0;
            sticky_q <= 1'b0;
        end else begin
            if (advance) begin
                node_q <= node_d;
                v_q    <= v_d;
            end
            sticky_q <= sticky_d;
        end
    end

    assign in_ready_o  = advance;
    assign out_o       = node[1];
    assign out_valid_o = v_q[LEVELS];
    assign sticky_o    = sticky_q;
endmodule

// File: tb/tb_student_or_reduce_pipe.sv
// Directed bench for student_or_reduce_pipe at WIDTH 16, 5 and 2.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.

module tb_student_or_reduce_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [15:0] a_in;
    logic        a_iv, a_ir, a_out, a_ov, a_ordy, a_st, a_clr;
    logic [4:0]  b_in;
    logic        b_iv, b_ir, b_out, b_ov, b_ordy, b_st, b_clr;
    logic [1:0]  c_in;
    logic        c_iv, c_ir, c_out, c_ov, c_ordy, c_st, c_clr;

    int n_chk  = 0;
    int n_pass = 0;

    student_or_reduce_pipe #(.WIDTH(16)) u_w16 (
        .clk_i(clk), .reset_i(rst), .in_i(a_in), .in_valid_i(a_iv), .in_ready_o(a_ir),
        .out_o(a_out), .out_valid_o(a_ov), .out_ready_i(a_ordy), .sticky_o(a_st),
        .sticky_clear_i(a_clr)
    );
    student_or_reduce_pipe #(.WIDTH(5)) u_w5 (
        .clk_i(clk), .reset_i(rst), .in_i(b_in), .in_valid_i(b_iv), .in_ready_o(b_ir),
        .out_o(b_out), .out_valid_o(b_ov), .out_ready_i(b_ordy), .sticky_o(b_st),
        .sticky_clear_i(b_clr)
    );
    student_or_reduce_pipe #(.WIDTH(2)) u_w2 (
        .clk_i(clk), .reset_i(rst), .in_i(c_in), .in_valid_i(c_iv), .in_ready_o(c_ir),
        .out_o(c_out), .out_valid_o(c_ov), .out_ready_i(c_ordy), .sticky_o(c_st),
        .sticky_clear_i(c_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_in = '0; a_iv = 0; a_ordy = 1; a_clr = 0;
        b_in = '0; b_iv = 0; b_ordy = 1; b_clr = 0;
        c_in = '0; c_iv = 0; c_ordy = 1; c_clr = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    logic        ev, eo, er, es;
    logic [15:0] vecs [4];
    logic [3:0]  got_seq;
    int          n_xfer;

    initial begin
        idle();
        rst = 1'b1;
        #1;
        chk("rst_w16_ovalid", a_ov, 0);  chk("rst_w16_out", a_out, 0);
        chk("rst_w16_sticky", a_st, 0);  chk("rst_w16_iready", a_ir, 1);
        chk("rst_w5_ovalid", b_ov, 0);   chk("rst_w2_ovalid", c_ov, 0);
        chk("rst_w2_iready", c_ir, 1);
        cyc();
        cyc();
        rst = 1'b0;

        // One-hot sweep, back to back, 4-cycle latency with no gaps.
        for (int c = 0; c < 24; c++) begin
            a_iv = (c < 17);
            a_in = (c >= 1 && c <= 16) ? (16'(1) << (c - 1)) : 16'h0000;
            @(negedge clk);
            ev = (c >= 4 && c < 21);
            chk($sformatf("sweep_ovalid[%0d]", c), a_ov, ev);
            if (ev) chk($sformatf("sweep_out[%0d]", c), a_out, (c != 4));
            chk($sformatf("sweep_iready[%0d]", c), a_ir, 1);
            cyc();
        end
        chk("sweep_sticky", a_st, 1);

        // Reset between edges while stalled with a full pipeline.
        for (int c = 0; c < 5; c++) begin
            a_ordy = 0;
            a_iv   = (c < 3);
            a_in   = 16'hFFFF;
            @(negedge clk);
            if (c == 3) chk("inflight_ovalid_c3", a_ov, 0);
            if (c == 4) begin
                chk("inflight_ovalid_c4", a_ov, 1);
                chk("inflight_out_c4", a_out, 1);
                chk("inflight_iready_c4", a_ir, 0);
                chk("inflight_sticky_c4", a_st, 1);
            end
            cyc();
        end
        a_iv = 0;
        #3 rst = 1'b1;
        #1;
        chk("async_rst_ovalid", a_ov, 0);
        chk("async_rst_out", a_out, 0);
        chk("async_rst_sticky", a_st, 0);
        chk("async_rst_iready", a_ir, 1);
        cyc();
        rst = 1'b0;
        a_ordy = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_ovalid[%0d]", c), a_ov, 0);
            cyc();
        end

        // Stall for three cycles once the first result appears.
        do_reset();
        vecs[0] = 16'h0000; vecs[1] = 16'h0100; vecs[2] = 16'h0000; vecs[3] = 16'hFFFF;
        got_seq = '0;
        n_xfer  = 0;
        for (int c = 0; c < 13; c++) begin
            a_iv   = (c < 4);
            a_in   = (c < 4) ? vecs[c] : 16'h0000;
            a_ordy = !(c >= 4 && c <= 6);
            @(negedge clk);
            ev = (c >= 4 && c <= 10);
            eo = (c == 8 || c == 10);
            er = !(c >= 4 && c <= 6);
            chk($sformatf("stall_ovalid[%0d]", c), a_ov, ev);
            if (ev) chk($sformatf("stall_out[%0d]", c), a_out, eo);
            chk($sformatf("stall_iready[%0d]", c), a_ir, er);
            if (a_ov && a_ordy) begin
                if (n_xfer < 4) got_seq[3 - n_xfer] = a_out;
                n_xfer++;
            end
            cyc();
        end
        chk("stall_xfer_count", n_xfer, 4);
        chk("stall_xfer_seq", got_seq, 4'b0101);

        // Sticky: set on a 1 transfer, set beats coincident clear, clear alone drops it.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            a_iv  = (c < 3) || (c == 8);
            a_in  = (c == 1) ? 16'h0001 : (c == 8) ? 16'h0002 : 16'h0000;
            a_clr = (c == 12) || (c == 14);
            @(negedge clk);
            es = (c >= 6 && c <= 14);
            chk($sformatf("sticky[%0d]", c), a_st, es);
            if (c == 12) begin
                chk("sticky_coinc_ovalid", a_ov, 1);
                chk("sticky_coinc_out", a_out, 1);
            end
            cyc();
        end
        a_clr = 0;

        // WIDTH=5 (3-cycle latency, padding) and WIDTH=2 (1-cycle latency) together.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            b_iv = (c < 2);
            b_in = (c == 0) ? 5'b10000 : 5'b00000;
            c_iv = (c < 3);
            c_in = (c == 0) ? 2'b01 : (c == 1) ? 2'b10 : 2'b00;
            @(negedge clk);
            ev = (c == 3 || c == 4);
            chk($sformatf("w5_ovalid[%0d]", c), b_ov, ev);
            if (ev) chk($sformatf("w5_out[%0d]", c), b_out, (c == 3));
            ev = (c >= 1 && c <= 3);
            chk($sformatf("w2_ovalid[%0d]", c), c_ov, ev);
            if (ev) chk($sformatf("w2_out[%0d]", c), c_out, (c != 3));
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1);
    end
endmodule
